polynomial_estimator_mc: RTL

Multi-channel successor to the single-bank polynomial estimator: evaluates y = c0 + c1·x + … + c(N−1)·x^(N−1) on IEEE-754 single-precision samples, using one coefficient bank per channel and Horner's method. It shares one `floating_point_mult_valid_only` and one `floating_point_add_valid_only` instance with no other logic. It sits in the float sample chain between valid/ready stages. Each input sample is tagged with a channel, and the tag is carried to the output. Coefficients can be reprogrammed at runtime without a reset.

---
 rtl/polynomial_estimator_mc.sv | 295 +++++++++++++++++++++++++++++
 1 files changed

// File: rtl/polynomial_estimator_mc.sv
// polynomial_estimator_mc
//   Multi-channel Horner evaluator y = c0 + c1*x + ... + c(N-1)*x^(N-1) on
//   IEEE-754 single-precision samples. There is one coefficient bank per
//   channel, and one shared multiplier and adder, each with one-cycle latency.
//   Optional macro POLY_EST_OUT_CLAMP_EN clamps the result magnitude to G_CLAMP_MAG.
// Ports:
//   clk, reset (sync, active-high), enable (low = reset), bypass (comb passthrough)
//   taps_prog_din/_valid/_ready, taps_prog_done, taps_reprog : coefficient load
//   din/din_chan/din_valid/din_ready   : sample input
//   dout/dout_chan/dout_valid/dout_ready : result output

// Float multiply with a registered result (latency 1). Truncating rounding;
// denormals are flushed to zero.
module floating_point_mult_valid_only (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid
);
  logic [23:0] w_ma, w_mb;
  logic [47:0] w_prod;
  logic [9:0]  w_exp;
  logic [31:0] w_res;

  always_comb begin
    w_ma   = {1'b1, din1[22:0]};
    w_mb   = {1'b1, din2[22:0]};
    w_prod = 48'(w_ma) * 48'(w_mb);
    w_exp  = {2'b0, din1[30:23]} + {2'b0, din2[30:23]} - 10'd127 + {9'b0, w_prod[47]};
    w_res  = {din1[31] ^ din2[31], 31'b0};
    if (din1[30:23] == 8'd0 || din2[30:23] == 8'd0)
      w_res = {din1[31] ^ din2[31], 31'b0};
    else if (din1[30:23] == 8'hFF || din2[30:23] == 8'hFF)
      w_res = {din1[31] ^ din2[31], 8'hFF, 23'b0};
    else if (w_exp[9] || w_exp == 10'd0)
      w_res = {din1[31] ^ din2[31], 31'b0};
    else if (w_exp >= 10'd255)
      w_res = {din1[31] ^ din2[31], 8'hFF, 23'b0};
    else
      w_res = {din1[31] ^ din2[31], w_exp[7:0],
               w_prod[47] ? w_prod[46:24] : w_prod[45:23]};
  end

  always_ff @(posedge clk) begin
    if (reset) dout_valid <= 1'b0;
    else       dout_valid <= din_valid;
    if (din_valid) dout <= w_res;
  end
endmodule

// Float add with a registered result (latency 1). Truncating alignment;
// denormals are treated as zero.
module floating_point_add_valid_only (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] din1,
  input  logic [31:0] din2,
  input  logic        din_valid,
  output logic [31:0] dout,
  output logic        dout_valid
);
  logic [31:0] w_big, w_small, w_res;
  logic [7:0]  w_d;
  logic [23:0] w_ms, w_diff, w_norm;
  logic [24:0] w_sum;
  logic [4:0]  w_lz;
  logic        w_found;
  logic [9:0]  w_e;

  always_comb begin
    // Order operands by magnitude so the difference path never goes negative.
    if (din1[30:0] < din2[30:0]) begin w_big = din2; w_small = din1; end
    else                         begin w_big = din1; w_small = din2; end
    w_d    = w_big[30:23] - w_small[30:23];
    w_ms   = (w_d >= 8'd24) ? 24'd0 : ({1'b1, w_small[22:0]} >> w_d);
    w_sum  = {2'b01, w_big[22:0]} + {1'b0, w_ms};
    w_diff = {1'b1, w_big[22:0]} - w_ms;
    w_lz    = '0;
    w_found = 1'b0;
    for (int unsigned i = 0; i < 24; i++) begin
      if (!w_found && w_diff[23 - i]) begin
        w_lz    = 5'(i);
        w_found = 1'b1;
      end
    end
    w_norm = w_diff << w_lz;
    w_e    = '0;
    if (w_big[30:23] == 8'hFF || w_small[30:23] == 8'd0) begin
      w_res = w_big;
    end else if (w_big[31] == w_small[31]) begin
      w_e = {2'b0, w_big[30:23]} + {9'b0, w_sum[24]};
      if (w_e >= 10'd255) w_res = {w_big[31], 8'hFF, 23'b0};
      else w_res = {w_big[31], w_e[7:0], w_sum[24] ? w_sum[23:1] : w_sum[22:0]};
    end else if (w_diff == 24'd0) begin
      w_res = '0;
    end else begin
      w_e = {2'b0, w_big[30:23]} - {5'b0, w_lz};
      if (w_e[9] || w_e == 10'd0) w_res = {w_big[31], 31'b0};
      else                        w_res = {w_big[31], w_e[7:0], w_norm[22:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) dout_valid <= 1'b0;
    else       dout_valid <= din_valid;
    if (din_valid) dout <= w_res;
  end
endmodule

module polynomial_estimator_mc #(
  parameter int          G_POLY_ORDER   = 5,
  parameter int          G_NUM_CHANNELS = 2,
  parameter logic [31:0] G_CLAMP_MAG    = 32'h7F7FFFFF,
  localparam int         C_CW           = (G_NUM_CHANNELS > 1) ? $clog2(G_NUM_CHANNELS) : 1,
  localparam int         C_FP_DWIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   bypass,
  input  logic [C_FP_DWIDTH-1:0] taps_prog_din,
  input  logic                   taps_prog_din_valid,
  output logic                   taps_prog_din_ready,
  output logic                   taps_prog_done,
  input  logic                   taps_reprog,
  input  logic [C_FP_DWIDTH-1:0] din,
  input  logic [C_CW-1:0]        din_chan,
  input  logic                   din_valid,
  output logic                   din_ready,
  output logic [C_FP_DWIDTH-1:0] dout,
  output logic [C_CW-1:0]        dout_chan,
  output logic                   dout_valid,
  input  logic                   dout_ready
);
  localparam int C_TOT = G_NUM_CHANNELS * G_POLY_ORDER;
  localparam int C_KW  = (C_TOT > 1) ? $clog2(C_TOT) : 1;

  typedef enum logic [2:0] {
    SM_INIT, SM_PROG_TAPS, SM_GET_INPUT, SM_MULT,
    SM_WAIT_MULT, SM_ADD, SM_WAIT_ADD, SM_SEND_OUTPUT
  } t_state;

  t_state      r_state;
  logic [31:0] r_coef [C_TOT];
  logic [C_KW-1:0] r_k;
  logic [31:0] r_x, r_acc, r_prod, r_dout;
  logic [C_CW-1:0] r_chan, r_dout_chan;
  logic [7:0]  r_idx;
  logic        r_mult_valid, r_add_valid;
  logic        r_din_ready, r_dout_valid, r_prog_ready, r_prog_done;

  logic            w_rst;
  logic [C_CW-1:0] w_chan_eff;
  logic [C_KW-1:0] w_addr;
  logic [31:0]     w_coef, w_mult_dout, w_add_dout;
  logic            w_mult_valid, w_add_valid;

  assign w_rst = reset | ~enable;

  // Out-of-range channel tags fall back to bank 0.
  always_comb begin
    w_chan_eff = (int'(din_chan) >= G_NUM_CHANNELS) ? '0 : din_chan;
    // While idle the address targets the top coefficient of the incoming
    // channel, so acc can be seeded in the same cycle as the handshake.
    if (r_state == SM_GET_INPUT)
      w_addr = C_KW'(int'(w_chan_eff) * G_POLY_ORDER + (G_POLY_ORDER - 1));
    else
      w_addr = C_KW'(int'(r_chan) * G_POLY_ORDER + int'(r_idx));
    w_coef = r_coef[w_addr];
  end

  function automatic logic [31:0] f_out(input logic [31:0] v);
`ifdef POLY_EST_OUT_CLAMP_EN
    if (v[30:0] > G_CLAMP_MAG[30:0]) return {v[31], G_CLAMP_MAG[30:0]};
`endif
    return v;
  endfunction

  floating_point_mult_valid_only u_mult (
    .clk(clk), .reset(w_rst), .din1(r_acc), .din2(r_x),
    .din_valid(r_mult_valid), .dout(w_mult_dout), .dout_valid(w_mult_valid)
  );

  floating_point_add_valid_only u_add (
    .clk(clk), .reset(w_rst), .din1(r_prod), .din2(w_coef),
    .din_valid(r_add_valid), .dout(w_add_dout), .dout_valid(w_add_valid)
  );

  // Coefficient storage is deliberately not cleared by reset.
  always_ff @(posedge clk) begin
    if (!w_rst && r_state == SM_PROG_TAPS && taps_prog_din_valid && r_prog_ready)
      r_coef[r_k] <= taps_prog_din;
  end

  always_ff @(posedge clk) begin
    if (w_rst) begin
      r_state      <= SM_INIT;
      r_din_ready  <= 1'b0;
      r_dout_valid <= 1'b0;
      r_prog_ready <= 1'b0;
      r_prog_done  <= 1'b0;
      r_mult_valid <= 1'b0;
      r_add_valid  <= 1'b0;
    end else begin
      r_mult_valid <= 1'b0;
      r_add_valid  <= 1'b0;
      case (r_state)
        SM_INIT: begin
          r_prog_ready <= 1'b1;
          r_k          <= '0;
          r_state      <= SM_PROG_TAPS;
        end
        SM_PROG_TAPS: begin
          if (taps_prog_din_valid && r_prog_ready) begin
            if (r_k == C_KW'(C_TOT - 1)) begin
              r_prog_ready <= 1'b0;
              r_prog_done  <= 1'b1;
              r_din_ready  <= 1'b1;
              r_state      <= SM_GET_INPUT;
            end else begin
              r_k <= r_k + 1'b1;
            end
          end
        end
        SM_GET_INPUT: begin
          if (taps_reprog) begin
            r_din_ready <= 1'b0;
            r_prog_done <= 1'b0;
            r_state     <= SM_INIT;
          end else if (din_valid && r_din_ready) begin
            r_x         <= din;
            r_chan      <= w_chan_eff;
            r_acc       <= w_coef;
            r_idx       <= 8'((G_POLY_ORDER >= 2) ? G_POLY_ORDER - 2 : 0);
            r_din_ready <= 1'b0;
            if (G_POLY_ORDER == 1) begin
              r_dout       <= f_out(w_coef);
              r_dout_chan  <= w_chan_eff;
              r_dout_valid <= 1'b1;
              r_state      <= SM_SEND_OUTPUT;
            end else begin
              r_state <= SM_MULT;
            end
          end
        end
        SM_MULT: begin
          r_mult_valid <= 1'b1;
          r_state      <= SM_WAIT_MULT;
        end
        SM_WAIT_MULT: begin
          if (w_mult_valid) begin
            r_prod  <= w_mult_dout;
            r_state <= SM_ADD;
          end
        end
        SM_ADD: begin
          r_add_valid <= 1'b1;
          r_state     <= SM_WAIT_ADD;
        end
        SM_WAIT_ADD: begin
          if (w_add_valid) begin
            r_acc <= w_add_dout;
            if (r_idx == 8'd0) begin
              r_dout       <= f_out(w_add_dout);
              r_dout_chan  <= r_chan;
              r_dout_valid <= 1'b1;
              r_state      <= SM_SEND_OUTPUT;
            end else begin
              r_idx   <= r_idx - 1'b1;
              r_state <= SM_MULT;
            end
          end
        end
        SM_SEND_OUTPUT: begin
          if (dout_ready) begin
            r_dout_valid <= 1'b0;
            r_din_ready  <= 1'b1;
            r_state      <= SM_GET_INPUT;
          end
        end
        default: r_state <= SM_INIT;
      endcase
    end
  end

  assign taps_prog_din_ready = r_prog_ready;
  assign taps_prog_done      = r_prog_done;
  assign dout       = bypass ? din        : r_dout;
  assign dout_chan  = bypass ? din_chan   : r_dout_chan;
  assign dout_valid = bypass ? din_valid  : r_dout_valid;
  assign din_ready  = bypass ? dout_ready : r_din_ready;
endmodule
